// File: rtl/led_seq_pkg.sv
// Shared constants and helpers for the LED pattern sequencer family.
package led_seq_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    // Widest LED bank the seed helper supports; callers truncate to their width.
    localparam int MAX_LEDS = 64;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic logic [MAX_LEDS-1:0] seed_for_mode(input logic [1:0] mode);
        logic [MAX_LEDS-1:0] seed;
        case (mode)
            MODE_COUNT: seed = {MAX_LEDS{1'b0}};
            default:    seed = {{(MAX_LEDS-1){1'b0}}, 1'b1};
        endcase
        return seed;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a single-cycle step strobe every max(1, TICK_CYCLES >> speed) enabled cycles.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] speed_i,
    output logic       step_now_o
);

    localparam int CNT_W = $clog2(TICK_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TICK_W = CNT_W'(TICK_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_s;
    logic             step_s;

    // Period selection and compare; >= lets a shortened period fire immediately.
    always_comb begin
        period_s = TICK_W >> speed_i;
        if (period_s == {CNT_W{1'b0}}) begin
            period_s = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            period_s = TICK_W >> speed_i;
        end
        step_s = 1'b0;
        cnt_d  = cnt_q;
        if (en_i) begin
            if (cnt_q >= period_s - {{(CNT_W-1){1'b0}}, 1'b1}) begin
                step_s = 1'b1;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            step_s = 1'b0;
            cnt_d  = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_now_o = step_s;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotate, bounce or binary-count patterns on an active-low LED bank.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 6,
    parameter int CLK_HZ   = 27_000_000,
    parameter int STEP_MS  = 500
) (
    input  logic                clk_in,
    input  logic                btn_rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    localparam int TICK_CYCLES = CLK_HZ / 1000 * STEP_MS;
    localparam logic [NUM_LEDS-1:0] PAT_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    logic                step_now_s;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    dir_e                dir_q, dir_d;
    logic [1:0]          mode_q, mode_d;
    logic [NUM_LEDS-1:0] led_q;
    logic                tick_q;

    led_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk_i      (clk_in),
        .rst_i      (btn_rst),
        .en_i       (en),
        .speed_i    (speed),
        .step_now_o (step_now_s)
    );

    // Next pattern: a mode change reloads the seed instead of stepping.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        if (step_now_s) begin
            if (mode != mode_q) begin
                mode_d    = mode;
                pattern_d = NUM_LEDS'(seed_for_mode(mode));
                dir_d     = DIR_LEFT;
            end else begin
                case (mode_q)
                    MODE_ROT_L: pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                    MODE_ROT_R: pattern_d = {pattern_q[0], pattern_q[NUM_LEDS-1:1]};
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            if (pattern_q[NUM_LEDS-1]) begin
                                pattern_d = pattern_q >> 1;
                                dir_d     = DIR_RIGHT;
                            end else begin
                                pattern_d = pattern_q << 1;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                pattern_d = pattern_q << 1;
                                dir_d     = DIR_LEFT;
                            end else begin
                                pattern_d = pattern_q >> 1;
                            end
                        end
                    end
                    MODE_COUNT: pattern_d = pattern_q + PAT_ONE;
                    default:    pattern_d = pattern_q;
                endcase
            end
        end else begin
            pattern_d = pattern_q;
        end
    end

    // Pattern state plus registered LED drive and tick strobe.
    always_ff @(posedge clk_in) begin
        if (btn_rst) begin
            pattern_q <= PAT_ONE;
            dir_q     <= DIR_LEFT;
            mode_q    <= MODE_ROT_L;
            led_q     <= ~PAT_ONE;
            tick_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            led_q     <= ~pattern_d;
            tick_q    <= step_now_s;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule
